// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - flow-controlled inter-stage register with 2-entry skid buffer and flush
module pipe_stage_skid #(
    parameter int CTRL_W         = 8,
    parameter int DATA_W         = 160,
    parameter int FLUSH_CLR_DATA = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occupancy_o
);

    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    logic accept;
    logic drain;

    // skid_valid is a flop, so upstream ready never depends on out_ready_i
    assign in_ready_o  = ~skid_valid;
    assign accept      = in_valid_i & ~skid_valid;
    assign drain       = main_valid & out_ready_i;

    assign out_valid_o = main_valid;
    assign out_ctrl_o  = main_valid ? main_ctrl : '0;
    assign out_data_o  = main_data;
    assign occupancy_o = {1'b0, main_valid} + {1'b0, skid_valid};

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
            skid_data  <= '0;
        end else if (flush_i) begin
            // a concurrent drain has already been seen downstream; an accept is squashed
            main_valid <= 1'b0;
            main_ctrl  <= '0;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
            if (FLUSH_CLR_DATA != 0) begin
                main_data <= '0;
                skid_data <= '0;
            end
        end else if (skid_valid) begin
            if (drain) begin
                main_ctrl  <= skid_ctrl;
                main_data  <= skid_data;
                skid_valid <= 1'b0;
                skid_ctrl  <= '0;
            end
        end else if (accept && (!main_valid || drain)) begin
            main_valid <= 1'b1;
            main_ctrl  <= in_ctrl_i;
            main_data  <= in_data_i;
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_ctrl  <= in_ctrl_i;
            skid_data  <= in_data_i;
        end else if (drain) begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - self-checking bench for pipe_stage_skid
module tb_pipe_stage_skid;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [7:0]   in_ctrl_i;
    logic [159:0] in_data_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [7:0]   out_ctrl_o;
    logic [159:0] out_data_o;
    logic [1:0]   occupancy_o;

    int tests = 0;
    int fails = 0;

    pipe_stage_skid dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_ctrl_i   (in_ctrl_i),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_ctrl_o  (out_ctrl_o),
        .out_data_o  (out_data_o),
        .occupancy_o (occupancy_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]   c;
        logic [159:0] d;
    } beat_t;

    beat_t mq[$];
    beat_t got[$];
    logic  data_zero;
    logic  chk_en = 1'b0;
    bit    m_acc;
    bit    m_drn;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // FIFO model: capacity two, ready whenever fewer than two beats are held
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            data_zero <= 1'b1;
        end else begin
            m_acc = in_valid_i && (mq.size() < 2);
            m_drn = (mq.size() > 0) && out_ready_i;
            if (m_drn) got.push_back(mq.pop_front());
            if (flush_i) begin
                mq.delete();
                data_zero <= 1'b1;
            end else begin
                if (m_acc) mq.push_back({in_ctrl_i, in_data_i});
                if (m_acc || m_drn) data_zero <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (mq.size() > 0) begin
                chk("m_valid", {159'b0, out_valid_o}, 160'd1);
                chk("m_ctrl", {152'b0, out_ctrl_o}, {152'b0, mq[0].c});
                chk("m_data", out_data_o, mq[0].d);
            end else begin
                chk("m_valid", {159'b0, out_valid_o}, 160'd0);
                chk("m_ctrl", {152'b0, out_ctrl_o}, 160'd0);
                if (data_zero === 1'b1) chk("m_data_zero", out_data_o, 160'd0);
            end
            chk("m_ready", {159'b0, in_ready_o}, {159'b0, mq.size() < 2});
            chk("m_occ", {158'b0, occupancy_o}, 160'(mq.size()));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [7:0] c, input logic [159:0] d);
        in_valid_i = 1'b1;
        in_ctrl_i  = c;
        in_data_i  = d;
    endtask

    int base;

    initial begin
        rst         = 1'b1;
        flush_i     = 1'b0;
        out_ready_i = 1'b0;
        offer(8'hFF, {160{1'b1}});
        tick;
        chk_en = 1'b1;
        tick;
        chk("rst_valid", {159'b0, out_valid_o}, 160'd0);
        chk("rst_ctrl", {152'b0, out_ctrl_o}, 160'd0);
        chk("rst_data", out_data_o, 160'd0);
        chk("rst_occ", {158'b0, occupancy_o}, 160'd0);
        chk("rst_ready", {159'b0, in_ready_o}, 160'd1);
        rst        = 1'b0;
        in_valid_i = 1'b0;

        // single beat, one-cycle latency
        out_ready_i = 1'b1;
        offer(8'h05, {32'h12345678, 32'hABCDEF01, 32'hFEDCBA98, 32'h00001004, 32'h00002000});
        tick;
        in_valid_i = 1'b0;
        chk("single_valid", {159'b0, out_valid_o}, 160'd1);
        chk("single_ctrl", {152'b0, out_ctrl_o}, 160'h05);
        chk("single_data", out_data_o,
            {32'h12345678, 32'hABCDEF01, 32'hFEDCBA98, 32'h00001004, 32'h00002000});
        tick;
        chk("single_gone_valid", {159'b0, out_valid_o}, 160'd0);
        chk("single_gone_ctrl", {152'b0, out_ctrl_o}, 160'd0);

        // back-pressure fills the skid, then drains in order
        base        = got.size();
        out_ready_i = 1'b0;
        offer(8'h01, 160'hA);
        tick;
        chk("bp_occ1", {158'b0, occupancy_o}, 160'd1);
        offer(8'h02, 160'hB);
        tick;
        chk("bp_occ2", {158'b0, occupancy_o}, 160'd2);
        chk("bp_ready0", {159'b0, in_ready_o}, 160'd0);
        offer(8'h03, 160'hC);
        tick;
        chk("bp_hold_occ", {158'b0, occupancy_o}, 160'd2);
        chk("bp_hold_head", {152'b0, out_ctrl_o}, 160'h01);
        out_ready_i = 1'b1;
        tick;
        tick;
        in_valid_i = 1'b0;
        tick;
        tick;
        chk("bp_count", 160'(got.size() - base), 160'd3);
        if (got.size() - base == 3) begin
            chk("bp_order0", {152'b0, got[base].c}, 160'h01);
            chk("bp_order1", {152'b0, got[base+1].c}, 160'h02);
            chk("bp_order2", {152'b0, got[base+2].c}, 160'h03);
            chk("bp_data2", got[base+2].d, 160'hC);
        end

        // streaming at full rate
        base = got.size();
        for (int i = 0; i < 16; i++) begin
            offer(8'h40, 160'(i));
            tick;
            chk("stream_occ_le1", {159'b0, occupancy_o <= 2'd1}, 160'd1);
            chk("stream_ready", {159'b0, in_ready_o}, 160'd1);
        end
        in_valid_i = 1'b0;
        tick;
        tick;
        chk("stream_count", 160'(got.size() - base), 160'd16);
        if (got.size() - base == 16) begin
            for (int i = 0; i < 16; i++) chk("stream_data", got[base+i].d, 160'(i));
        end

        // flush while full with an accept attempt and a drain
        out_ready_i = 1'b0;
        offer(8'h11, 160'h111);
        tick;
        offer(8'h12, 160'h222);
        tick;
        chk("fl_full", {158'b0, occupancy_o}, 160'd2);
        base = got.size();
        offer(8'h13, 160'h333);
        flush_i     = 1'b1;
        out_ready_i = 1'b1;
        tick;
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        chk("fl_valid", {159'b0, out_valid_o}, 160'd0);
        chk("fl_ctrl", {152'b0, out_ctrl_o}, 160'd0);
        chk("fl_occ", {158'b0, occupancy_o}, 160'd0);
        chk("fl_ready", {159'b0, in_ready_o}, 160'd1);
        chk("fl_data", out_data_o, 160'd0);
        chk("fl_delivered", 160'(got.size() - base), 160'd1);
        if (got.size() - base == 1) chk("fl_head", {152'b0, got[base].c}, 160'h11);
        tick;
        tick;
        chk("fl_no_more", 160'(got.size() - base), 160'd1);

        // flush drops a beat accepted in the same cycle
        out_ready_i = 1'b0;
        base        = got.size();
        offer(8'h31, 160'h31);
        tick;
        offer(8'h32, 160'h32);
        flush_i = 1'b1;
        tick;
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        chk("fl1_occ", {158'b0, occupancy_o}, 160'd0);
        out_ready_i = 1'b1;
        tick;
        chk("fl1_none", 160'(got.size() - base), 160'd0);

        // reset while full, then a fresh beat
        out_ready_i = 1'b0;
        offer(8'h41, 160'h41);
        tick;
        offer(8'h42, 160'h42);
        tick;
        chk("rs_full", {158'b0, occupancy_o}, 160'd2);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        in_valid_i = 1'b0;
        chk("rs_valid", {159'b0, out_valid_o}, 160'd0);
        chk("rs_occ", {158'b0, occupancy_o}, 160'd0);
        chk("rs_ready", {159'b0, in_ready_o}, 160'd1);
        chk("rs_data", out_data_o, 160'd0);
        out_ready_i = 1'b1;
        offer(8'h21, 160'h87654321);
        tick;
        in_valid_i = 1'b0;
        chk("rs_new_valid", {159'b0, out_valid_o}, 160'd1);
        chk("rs_new_data", out_data_o, 160'h87654321);
        tick;
        tick;

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
